// File: rtl/lsu_mem_port.sv
// Load/store port between the RV32I core and a word-wide data memory.
// One request is handled at a time. Loads are sign- or zero-extended.
// Sub-word stores read the word first, merge the new lane into it, then
// write the whole word back. Misaligned, illegal-funct3 and out-of-range
// requests are rejected at accept and never reach the memory.
`timescale 1ns/1ps

module lsu_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    // First word index that lies outside the memory.
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH);

    state_t                state_q,  state_d;
    logic                  we_q,     we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  err_q,    err_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [DATA_WIDTH-1:0] wr_word;

    // Reject misaligned accesses, unsupported funct3 codes and word
    // indices beyond the end of the memory.
    function automatic logic req_error(
        input logic                  we,
        input logic [2:0]            f3,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (f3)
                3'd0:    bad = 1'b0;
                3'd1:    bad = addr[0];
                3'd2:    bad = |addr[1:0];
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: bad = 1'b0;
                3'd1, 3'd5: bad = addr[0];
                3'd2:       bad = |addr[1:0];
                default:    bad = 1'b1;
            endcase
        end
        if (addr[ADDR_WIDTH-1:2] >= DEPTH_LIM) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Select the byte and halfword lanes of the captured word and extend them.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no latch is inferred.
        ld_byte = 8'h00;
        ld_ext  = data_q;
        case (addr_q[1:0])
            2'd0: ld_byte = data_q[7:0];
            2'd1: ld_byte = data_q[15:8];
            2'd2: ld_byte = data_q[23:16];
            2'd3: ld_byte = data_q[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_q[1] ? data_q[31:16] : data_q[15:0];
        case (funct3_q)
            3'd0:    ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'd4:    ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'd1:    ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'd5:    ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = data_q;
        endcase
    end

    // Replace the addressed lane of the captured word with the store data.
    always_comb begin
        wr_word = data_q;
        case (funct3_q)
            3'd0: begin
                case (addr_q[1:0])
                    2'd0: wr_word[7:0]   = wdata_q[7:0];
                    2'd1: wr_word[15:8]  = wdata_q[7:0];
                    2'd2: wr_word[23:16] = wdata_q[7:0];
                    2'd3: wr_word[31:24] = wdata_q[7:0];
                    default: wr_word = data_q;
                endcase
            end
            3'd1: begin
                if (addr_q[1]) begin
                    wr_word[31:16] = wdata_q[15:0];
                end else begin
                    wr_word[15:0] = wdata_q[15:0];
                end
            end
            default: wr_word = wdata_q;
        endcase
    end

    // Next-state logic and all port outputs; outputs decode straight from
    // the state, so an asynchronous reset clears them at once.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        data_d      = data_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        mem_address = '0;
        mem_wd      = '0;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_error(req_we, req_funct3, req_addr);
                    state_d  = err_d ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_address = {2'b00, addr_q[ADDR_WIDTH-1:2]};
                data_d      = mem_rd;
                state_d     = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                mem_address = {2'b00, addr_q[ADDR_WIDTH-1:2]};
                mem_wd      = wr_word;
                mem_we      = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : ld_ext;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-request registers; reset discards any request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

endmodule
